// File: rtl/ama_riscv_bp.sv
// Conditional-branch direction predictor: PHT of 2-bit saturating counters, looked up at decode, trained at execute.
// Latency: lookup is combinational in the same cycle; a training write becomes visible at lookup the next cycle.
// Backpressure: none. Every update is accepted. bp_ready stays low while the post-reset init walk clears the table.
// Optional gshare indexing with global history is enabled by defining BP_GSHARE_EN. The default build is bimodal.

module ama_riscv_bp #(
    parameter int unsigned PHT_ENTRIES = 256,
    parameter int unsigned GHR_BITS    = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_dec,
    input  logic             branch_inst_dec,
    output logic             bp_pred,
    output logic             bp_ready,
    input  logic             upd_valid,
    input  logic [31:0]      pc_exe,
    input  logic             branch_resolution,
    input  logic             bp_hit,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_hit
);

    localparam int unsigned IDX_BITS = $clog2(PHT_ENTRIES);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_BITS-1:0] init_idx;
    logic [1:0]          pht [PHT_ENTRIES];

    logic [IDX_BITS-1:0] idx_l;
    logic [IDX_BITS-1:0] idx_u;
    logic                upd_en;
    logic [1:0]          cnt_u;
    logic [1:0]          cnt_nxt;
    logic                we;
    logic [IDX_BITS-1:0] wa;
    logic [1:0]          wd;
    logic                unused;

    // Bits of the PCs that never reach the index; the parameter is only meaningful for gshare.
    assign unused = ^{pc_dec[31:IDX_BITS+2], pc_dec[1:0],
                      pc_exe[31:IDX_BITS+2], pc_exe[1:0], 1'(GHR_BITS)};

    assign upd_en = (state == RUN) && upd_valid;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;
    logic [IDX_BITS-1:0] ghr_ext;

    assign ghr_ext = IDX_BITS'(ghr);
    // Both indices use the history as it stood before this cycle's shift.
    assign idx_l   = pc_dec[IDX_BITS+1:2] ^ ghr_ext;
    assign idx_u   = pc_exe[IDX_BITS+1:2] ^ ghr_ext;

    generate
        if (GHR_BITS == 1) begin : g_ghr1
            // Single-bit history simply records the last resolved direction.
            always_ff @(posedge clk) begin
                if (rst)         ghr <= '0;
                else if (upd_en) ghr <= branch_resolution;
            end
        end else begin : g_ghrn
            // Non-speculative history: shift in the resolved direction only.
            always_ff @(posedge clk) begin
                if (rst)         ghr <= '0;
                else if (upd_en) ghr <= {ghr[GHR_BITS-2:0], branch_resolution};
            end
        end
    endgenerate
`else
    assign idx_l = pc_dec[IDX_BITS+1:2];
    assign idx_u = pc_exe[IDX_BITS+1:2];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    // Leave INIT once the last table entry has been written.
    always_comb begin
        state_nxt = state;
        if ((state == INIT) && (init_idx == IDX_BITS'(PHT_ENTRIES - 1))) state_nxt = RUN;
    end

    // Init walk pointer: one entry per cycle while in INIT.
    always_ff @(posedge clk) begin
        if (rst)                 init_idx <= '0;
        else if (state == INIT)  init_idx <= init_idx + 1'b1;
    end

    // Saturating counter training for the resolving branch.
    always_comb begin
        cnt_u   = pht[idx_u];
        cnt_nxt = cnt_u;
        if (branch_resolution) begin
            if (cnt_u != 2'b11) cnt_nxt = cnt_u + 2'b01;
        end else begin
            if (cnt_u != 2'b00) cnt_nxt = cnt_u - 2'b01;
        end
    end

    // Single write port shared by the init walk and training.
    always_comb begin
        we = 1'b0;
        wa = idx_u;
        wd = cnt_nxt;
        if (state == INIT) begin
            we = 1'b1;
            wa = init_idx;
            wd = 2'b01;
        end else if (upd_valid) begin
            we = 1'b1;
        end
    end

    // Table storage; no reset, the init walk clears it.
    always_ff @(posedge clk) begin
        if (!rst && we) pht[wa] <= wd;
    end

    // Statistics, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total <= '0;
            stat_hit   <= '0;
        end else if (upd_en) begin
            if (stat_total != {CNT_W{1'b1}})           stat_total <= stat_total + 1'b1;
            if (bp_hit && (stat_hit != {CNT_W{1'b1}})) stat_hit   <= stat_hit + 1'b1;
        end
    end

    assign bp_ready = (state == RUN);
    assign bp_pred  = (state == RUN) && branch_inst_dec && pht[idx_l][1];

endmodule

// File: tb/tb_ama_riscv_bp.sv
// Self-checking bench for ama_riscv_bp in its default bimodal build, 256 entries, 4-bit statistics.
// Latency: lookups are sampled on the falling edge; training takes effect at the following rising edge.
// Backpressure: not applicable. Expected values are queued when stimulus is driven and popped at sampling.

module tb_ama_riscv_bp;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_dec;
    logic          branch_inst_dec;
    logic          bp_pred;
    logic          bp_ready;
    logic          upd_valid;
    logic [31:0]   pc_exe;
    logic          branch_resolution;
    logic          bp_hit;
    logic [CW-1:0] stat_total;
    logic [CW-1:0] stat_hit;

    always #5 clk = ~clk;

    ama_riscv_bp #(.PHT_ENTRIES(256), .GHR_BITS(8), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_dec           (pc_dec),
        .branch_inst_dec  (branch_inst_dec),
        .bp_pred          (bp_pred),
        .bp_ready         (bp_ready),
        .upd_valid        (upd_valid),
        .pc_exe           (pc_exe),
        .branch_resolution(branch_resolution),
        .bp_hit           (bp_hit),
        .stat_total       (stat_total),
        .stat_hit         (stat_hit)
    );

    typedef struct {
        logic        upd;
        logic [31:0] pce;
        logic        res;
        logic        hit;
        logic [31:0] pcd;
        logic        br;
        logic        pred;
    } vec_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    localparam int S_PRED = 0, S_RDY = 1, S_TOT = 2, S_HIT = 3;

    vec_t vt[19];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_PRED:  return {31'd0, bp_pred};
            S_RDY:   return {31'd0, bp_ready};
            S_TOT:   return 32'(stat_total);
            default: return 32'(stat_hit);
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drive(input logic upd, input logic [31:0] pce, input logic res, input logic hit,
                         input logic [31:0] pcd, input logic br);
        upd_valid         = upd;
        pc_exe            = pce;
        branch_resolution = res;
        bp_hit            = hit;
        pc_dec            = pcd;
        branch_inst_dec   = br;
    endtask

    // Sample at the falling edge, drain the scoreboard, then step past the next rising edge.
    task automatic settle();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.name, actual(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    // Count rising edges from reset release until bp_ready rises, bounded.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bp_ready && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        cmp(name, 32'(n), 32'd256);
        @(posedge clk);
        #1;
    endtask

    task automatic upd_n(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, 32'h200, 1'b1, 1'b1, 32'h0, 1'b0);
            settle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_tot;
        int exp_hit;

        //          upd   pc_exe     res   hit   pc_dec     br    pred
        vt[0]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1};
        vt[3]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1};
        vt[4]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h500, 1'b1, 1'b0};
        vt[10] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h500, 1'b1, 1'b1};
        vt[11] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0};
        vt[12] = '{1'b1, 32'h040, 1'b1, 1'b0, 32'h040, 1'b1, 1'b0};
        vt[13] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h040, 1'b1, 1'b1};
        vt[14] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h044, 1'b1, 1'b0};
        vt[15] = '{1'b1, 32'h3FC, 1'b1, 1'b1, 32'h3FC, 1'b1, 1'b0};
        vt[16] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h3FC, 1'b1, 1'b1};
        vt[17] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0};
        vt[18] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1};

        // Reset state.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1);
        @(posedge clk);
        #1;
        expect_val("rst_pred", S_PRED, 32'd0);
        expect_val("rst_ready", S_RDY, 32'd0);
        expect_val("rst_total", S_TOT, 32'd0);
        expect_val("rst_hit", S_HIT, 32'd0);
        settle();
        rst = 1'b0;
        wait_ready("init_len");

        // Freshly initialised table predicts not-taken everywhere.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h7F0, 1'b1);
        expect_val("post_init_pred", S_PRED, 32'd0);
        expect_val("post_init_total", S_TOT, 32'd0);
        expect_val("post_init_hit", S_HIT, 32'd0);
        settle();

        // Table-driven training and lookup.
        exp_tot = 0;
        exp_hit = 0;
        for (int i = 0; i < 19; i++) begin
            drive(vt[i].upd, vt[i].pce, vt[i].res, vt[i].hit, vt[i].pcd, vt[i].br);
            expect_val($sformatf("vec%0d_pred", i), S_PRED, {31'd0, vt[i].pred});
            expect_val($sformatf("vec%0d_total", i), S_TOT, 32'(exp_tot));
            expect_val($sformatf("vec%0d_hit", i), S_HIT, 32'(exp_hit));
            settle();
            if (vt[i].upd) begin
                exp_tot++;
                if (vt[i].hit) exp_hit++;
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_val("stats10_total", S_TOT, 32'd10);
        expect_val("stats10_hit", S_HIT, 32'd7);
        expect_val("run_ready", S_RDY, 32'd1);
        settle();

        // Statistics saturate instead of wrapping.
        upd_n(5);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_val("sat5_total", S_TOT, 32'd15);
        expect_val("sat5_hit", S_HIT, 32'd12);
        settle();
        upd_n(5);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_val("sat10_total", S_TOT, 32'd15);
        expect_val("sat10_hit", S_HIT, 32'd15);
        settle();
        upd_n(2);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h200, 1'b1);
        expect_val("sat12_total", S_TOT, 32'd15);
        expect_val("sat12_hit", S_HIT, 32'd15);
        expect_val("trained_200_pred", S_PRED, 32'd1);
        settle();

        // Reset mid-run, pulse updates through init, then reset again at cycle 100 of the walk.
        rst = 1'b1;
        settle();
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            drive(1'(c), 32'h200, 1'b1, 1'b1, 32'h200, 1'b1);
            if (c == 50) begin
                expect_val("init_pred_forced", S_PRED, 32'd0);
                expect_val("init_ready", S_RDY, 32'd0);
            end
            if (c == 99) begin
                expect_val("init_upd_total", S_TOT, 32'd0);
                expect_val("init_upd_hit", S_HIT, 32'd0);
            end
            settle();
        end
        rst = 1'b1;
        settle();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_ready("reinit_len");
        expect_val("reinit_total", S_TOT, 32'd0);
        expect_val("reinit_hit", S_HIT, 32'd0);
        settle();

        // Every entry must hold 01: not-taken now, taken after a single taken update.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'(i * 4), 1'b1);
            expect_val($sformatf("walk%0d_pre", i), S_PRED, 32'd0);
            settle();
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'(i * 4), 1'b1);
            expect_val($sformatf("walk%0d_post", i), S_PRED, 32'd1);
            settle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
